// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax output path.
//   SM_LANES / SM_DATA_W : lane count and lane width of a probability vector
//   len_mode_e           : row length mode carried alongside each vector
//   beats_per_row()      : output beats that make up one row in a given mode
package softmax_pkg;
  localparam int SM_LANES  = 64;
  localparam int SM_DATA_W = 16;
  localparam int SM_VEC_W  = SM_LANES * SM_DATA_W;

  typedef enum logic [1:0] {
    MODE_16 = 2'd0,
    MODE_32 = 2'd1,
    MODE_64 = 2'd2
  } len_mode_e;

  // Encoding 3 is not a legal mode but is handled like MODE_64.
  function automatic logic [4:0] beats_per_row(input logic [1:0] mode,
                                               input int lanes_per_beat);
    int row_lanes;
    case (mode)
      MODE_16: row_lanes = 16;
      MODE_32: row_lanes = 32;
      default: row_lanes = SM_LANES;
    endcase
    return 5'(row_lanes / lanes_per_beat);
  endfunction
endpackage

// File: rtl/softmax_vec_buf.sv
// Vector buffer: DEPTH entries of {length_mode, probability vector}.
//   clk_i, rst_ni   : clock, async active-low reset (contents cleared)
//   we_i            : write entry wr_ptr_i with wr_data_i
//   rd_ptr_i        : entry presented combinationally on rd_data_o
module softmax_vec_buf
  import softmax_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int EW    = SM_VEC_W + 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] wr_ptr_i,
  input  logic [EW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_ptr_i,
  output logic [EW-1:0] rd_data_o
);
  logic [DEPTH-1:0][EW-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   mem_q <= '0;
    else if (we_i) mem_q[wr_ptr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_i];
endmodule

// File: rtl/softmax_out_serializer.sv
// Buffers softmax probability vectors and streams them as 64-bit beats.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_en, i_valid         : capture qualifier / softmax output valid
//   i_prob_flat           : 64 x 16-bit lanes, lane k at [k*16 +: 16]
//   i_length_mode         : row length mode of the arriving vector
//   o_valid, i_ready      : output beat handshake
//   o_data                : 4 lanes of the head vector, lowest lane in [15:0]
//   o_last, o_row_idx     : row end marker and row index within the vector
//   o_level, o_overflow   : occupied entries, sticky dropped-vector flag
import softmax_pkg::*;

module softmax_out_serializer #(
  parameter int DEPTH          = 2,
  parameter int LANES_PER_BEAT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic [1023:0] i_prob_flat,
  input  logic [1:0]    i_length_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [63:0]   o_data,
  output logic          o_last,
  output logic [1:0]    o_row_idx,
  output logic [2:0]    o_level,
  output logic          o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = SM_VEC_W + 2;

  typedef enum logic {S_EMPTY, S_STREAM} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic [3:0]    beat_q, beat_d;
  logic          ovf_q, ovf_d;

  logic          cap, pop, last_pop, full, accept;
  logic [EW-1:0] rd_entry;
  logic [1:0]    rd_mode;
  logic [4:0]    bpr_m1;

  assign cap      = i_en && i_valid;
  assign pop      = o_valid && i_ready;
  assign last_pop = pop && (beat_q == 4'd15);
  assign full     = (count_q == 3'(DEPTH));
  // When full, the head entry is freed by the final-beat pop on this edge;
  // wr_ptr == rd_ptr then, so the new vector lands in the slot being vacated.
  assign accept   = cap && (!full || last_pop);

  softmax_vec_buf #(.DEPTH(DEPTH), .AW(AW), .EW(EW)) u_buf (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .we_i      (accept),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i ({i_length_mode, i_prob_flat}),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q | (cap && !accept);
    count_d  = count_q + {2'b0, accept} - {2'b0, last_pop};
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    case (state_q)
      S_EMPTY: begin
        if (count_d != 3'd0) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (pop) begin
          beat_d = beat_q + 4'd1;
          if (last_pop) begin
            beat_d   = 4'd0;
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = (count_d != 3'd0) ? S_STREAM : S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign rd_mode = rd_entry[EW-1 -: 2];
  // Beats per row is a power of two, so the low bits of beat_q give the
  // position within the row.
  assign bpr_m1  = beats_per_row(rd_mode, LANES_PER_BEAT) - 5'd1;

  always_comb begin
    o_valid   = (state_q == S_STREAM);
    o_data    = '0;
    o_last    = 1'b0;
    o_row_idx = 2'd0;
    if (o_valid) begin
      o_data = rd_entry[{beat_q, 6'b0} +: 64];
      o_last = (({1'b0, beat_q} & bpr_m1) == bpr_m1);
      case (rd_mode)
        MODE_16: o_row_idx = beat_q[3:2];
        MODE_32: o_row_idx = {1'b0, beat_q[3]};
        default: o_row_idx = 2'd0;
      endcase
    end
  end

  assign o_level    = count_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_softmax_out_serializer.sv
module tb_softmax_out_serializer;
  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_en = 1'b0;
  logic          i_valid = 1'b0;
  logic [1023:0] i_prob_flat = '0;
  logic [1:0]    i_length_mode = 2'd0;
  logic          i_ready = 1'b0;
  logic          o_valid, o_last, o_overflow;
  logic [63:0]   o_data;
  logic [1:0]    o_row_idx;
  logic [2:0]    o_level;

  softmax_out_serializer #(.DEPTH(2), .LANES_PER_BEAT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid),
    .i_prob_flat(i_prob_flat), .i_length_mode(i_length_mode),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_row_idx(o_row_idx), .o_level(o_level), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [1:0]  r;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Expected beats of a vector whose lane k holds base+k.
  task automatic push_vec(input logic [15:0] base, input logic [1:0] mode);
    exp_t e;
    for (int b = 0; b < 16; b++) begin
      for (int j = 0; j < 4; j++) e.d[j*16 +: 16] = base + 16'(4*b + j);
      case (mode)
        2'd0:    begin e.l = ((b % 4) == 3); e.r = 2'(b / 4); end
        2'd1:    begin e.l = ((b % 8) == 7); e.r = 2'(b / 8); end
        default: begin e.l = (b == 15);      e.r = 2'd0;     end
      endcase
      sb.push_back(e);
    end
  endtask

  task automatic capture(input logic [15:0] base, input logic [1:0] mode, input bit expect_out);
    for (int k = 0; k < 64; k++) i_prob_flat[k*16 +: 16] = base + 16'(k);
    i_length_mode = mode;
    i_en = 1'b1;
    i_valid = 1'b1;
    if (expect_out) push_vec(base, mode);
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((o_valid || o_level != 3'd0) && n < 200) begin
      cyc();
      n++;
    end
    n_vec++;
    if (n >= 200) begin
      n_err++;
      $display("FAIL %s drain timeout level=%0d want=0", name, o_level);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    sb.delete();
    repeat (2) cyc();
    i_rst_n = 1'b1;
    cyc();
  endtask

  // Monitor: compares every presented beat against the scoreboard head and
  // pops on handshake; a held beat is re-checked each cycle, so it must stay put.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat got=%h want=none", o_data);
        end else begin
          chk("beat_data", o_data, sb[0].d);
          chk("beat_last", 64'(o_last), 64'(sb[0].l));
          chk("beat_row", 64'(o_row_idx), 64'(sb[0].r));
          if (i_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_outputs", {o_data[61:0], o_last, o_row_idx[0]} | 64'(o_row_idx[1]), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_row", 64'(o_row_idx), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    repeat (2) cyc();
    i_rst_n = 1'b1;
    cyc();

    // Mode 2, lane k = k, first beat visible right after the capture edge
    i_ready = 1'b1;
    capture(16'h0000, 2'd2, 1'b1);
    chk("lat_valid", 64'(o_valid), 64'd1);
    chk("beat0_data", o_data, 64'h0003_0002_0001_0000);
    wait_empty("mode2");

    // Mode 0: last every 4 beats, rows 0..3
    capture(16'h0100, 2'd0, 1'b1);
    wait_empty("mode0");

    // Mode 1 with a 10-cycle stall at beat 5
    i_ready = 1'b0;
    capture(16'h0200, 2'd1, 1'b1);
    i_ready = 1'b1;
    repeat (5) cyc();
    i_ready = 1'b0;
    repeat (10) cyc();
    chk("hold_beat5", o_data, 64'h0217_0216_0215_0214);
    i_ready = 1'b1;
    wait_empty("mode1_hold");

    // Three captures back to back into a two-entry buffer
    i_ready = 1'b0;
    capture(16'h0400, 2'd2, 1'b1);
    capture(16'h0500, 2'd0, 1'b1);
    capture(16'h0600, 2'd2, 1'b0);
    chk("ovf_level", 64'(o_level), 64'd2);
    chk("ovf_flag", 64'(o_overflow), 64'd1);
    i_ready = 1'b1;
    wait_empty("ovf_drain");
    chk("ovf_sticky", 64'(o_overflow), 64'd1);

    // Full buffer with capture on the final-beat pop edge
    do_reset();
    chk("ovf_cleared", 64'(o_overflow), 64'd0);
    i_ready = 1'b0;
    capture(16'h0700, 2'd2, 1'b1);
    capture(16'h0800, 2'd1, 1'b1);
    chk("full_level", 64'(o_level), 64'd2);
    i_ready = 1'b1;
    repeat (15) cyc();
    capture(16'h0900, 2'd0, 1'b1);
    chk("swap_level", 64'(o_level), 64'd2);
    chk("swap_ovf", 64'(o_overflow), 64'd0);
    wait_empty("swap_drain");

    // i_valid held across disabled cycles: one capture only (mode 3 vector)
    i_ready = 1'b0;
    for (int k = 0; k < 64; k++) i_prob_flat[k*16 +: 16] = 16'h0A00 + 16'(k);
    i_length_mode = 2'd3;
    i_valid = 1'b1;
    i_en = 1'b0;
    repeat (3) cyc();
    chk("en_gate_level", 64'(o_level), 64'd0);
    i_en = 1'b1;
    push_vec(16'h0A00, 2'd3);
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("en_one_capture", 64'(o_level), 64'd1);
    i_ready = 1'b1;
    wait_empty("en_drain");

    // Reset asserted at beat 8
    capture(16'h0B00, 2'd2, 1'b1);
    repeat (8) cyc();
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mrst_valid", 64'(o_valid), 64'd0);
    chk("mrst_data", o_data, 64'd0);
    chk("mrst_last", 64'(o_last), 64'd0);
    chk("mrst_row", 64'(o_row_idx), 64'd0);
    chk("mrst_level", 64'(o_level), 64'd0);
    repeat (2) cyc();
    i_rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_valid", 64'(o_valid), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/softmax_out_serializer.md
# softmax_out_serializer

Downstream of the 64-lane softmax approximation engine: captures each 1024-bit probability vector on the engine's `o_valid`, buffers up to two vectors, and streams them out as 64-bit beats (4 lanes each) under a valid/ready handshake. It marks row boundaries according to the length mode that produced the vector. The softmax engine has no backpressure, so this block absorbs the rate mismatch between it and the consumer (write-back DMA / next layer) and flags vectors it has to drop.

## Interface
Parameters:
- `DEPTH`, 2: vector buffer entries. Legal values are 2 and 4.
- `LANES_PER_BEAT`, 4: 16-bit lanes per output beat. Fixed at 4; 64 / 4 = 16 beats per vector.

Ports:
- `i_clk` input 1: single clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_en` input 1: global enable, shared with the softmax engine. Capture is qualified by it.
- `i_valid` input 1: softmax `o_valid`.
- `i_prob_flat` input 1024: softmax `o_prob_flat`. Lane k is `[k*16 +: 16]`.
- `i_length_mode` input 2: mode of the arriving vector (0 = 16, 1 = 32, 2 = 64, 3 treated as 64). Delay-matched externally so it is valid with `i_valid`.
- `o_valid` output 1: beat available.
- `i_ready` input 1: consumer accepts the beat.
- `o_data` output 64: lanes 4b..4b+3 of the head vector for beat b. Lane 4b is in `[15:0]`.
- `o_last` output 1: final beat of a row.
- `o_row_idx` output 2: row index within the vector (0..3 in mode 0, 0..1 in mode 1, 0 in mode 2/3).
- `o_level` output 3: number of occupied buffer entries.
- `o_overflow` output 1: sticky; a vector was dropped.

## Operation
- Capture event: `i_en && i_valid` at a rising edge. A capture stores `i_prob_flat` and `i_length_mode` into entry `wr_ptr`, then advances `wr_ptr` (mod DEPTH) and increments `count`.
- `i_valid` held high across `!i_en` cycles produces no extra captures.
- Read side FSM:
  - EMPTY: `o_valid` = 0.
  - STREAM: `o_valid` = 1; `beat_cnt` 0..15 selects lanes from entry `rd_ptr`.
  - Pop: on `o_valid && i_ready`, `beat_cnt` increments.
  - Vector done: at `beat_cnt` = 15 a pop also advances `rd_ptr`, decrements `count`, and clears `beat_cnt`. The next state is STREAM if `count` > 0 after the update, otherwise EMPTY.
- Row marking:
  - Beats per row: 4 (mode 0), 8 (mode 1), 16 (mode 2/3).
  - `o_last` = 1 when `beat_cnt` is the last beat of a row: `beat_cnt[1:0]`=3 in mode 0, `beat_cnt[2:0]`=7 in mode 1, `beat_cnt`=15 in mode 2/3.
  - `o_row_idx` = `beat_cnt` / beats-per-row.
- `o_data`, `o_last` and `o_row_idx` are forced to 0 when `o_valid` = 0.
- Full and drop:
  - A capture while `count` == DEPTH is dropped, unless the same edge pops the final beat (`beat_cnt` 15) of the head vector. In that case the capture is accepted and `count` stays DEPTH.
  - A dropped capture sets `o_overflow`. It stays set until reset and the buffer state is unchanged.
- Capture and final pop on the same edge with `count` < DEPTH: both take effect and `count` is unchanged.
- `i_ready` may be asserted at any time. `o_data` must not change while `o_valid && !i_ready`.

## Timing
- Reset (async assert, released synchronously to `i_clk`): `o_valid` 0, `o_data` 0, `o_last` 0, `o_row_idx` 0, `o_level` 0, `o_overflow` 0. All pointers, `count` and `beat_cnt` are 0 and buffer contents are 0.
- Latency: a capture at edge N into an empty buffer gives `o_valid` = 1 with beat 0 after edge N.
- Throughput: with `i_ready` held high, 16 cycles per vector. Back-to-back vectors stream with no bubble.
- Reset mid-stream: all buffered and partially streamed vectors are discarded; `o_valid` drops immediately on assertion.

## Structure
- `softmax_pkg` holds:
  - `SM_LANES` = 64, `SM_DATA_W` = 16;
  - the length-mode typedef (`MODE_16`, `MODE_32`, `MODE_64`);
  - function `beats_per_row(mode, LANES_PER_BEAT)`.
- Sub-module `softmax_vec_buf`: DEPTH × (1024 + 2)-bit storage with write port and combinational read of the entry at `rd_ptr`. Pointer, count and FSM logic stay in the top module.

## Test plan
- Single mode-2 vector, lane k = k, `i_ready` = 1 → 16 beats. Beat 0 `o_data` = 0x0003_0002_0001_0000. `o_last` only on beat 15; `o_row_idx` = 0.
- Mode-0 vector, `i_ready` = 1 → `o_last` on beats 3, 7, 11, 15; `o_row_idx` 0,1,2,3 per group.
- `i_ready` = 0 for 10 cycles mid-vector at beat 5 → beat 5 held stable, then streaming resumes at beat 5, not 6.
- Three captures 1 cycle apart, `i_ready` = 0 → `o_level` = 2, `o_overflow` = 1, third vector absent from the output.
- `count` = 2 with a capture on the same edge as the beat-15 pop → accepted, `o_overflow` stays 0, `o_level` stays 2.
- `i_valid` = 1 held across 3 cycles of `i_en` = 0 followed by 1 cycle with `i_en` = 1 → exactly one capture. Separately, `i_rst_n` pulsed low at beat 8 → all outputs 0 immediately and `o_level` = 0.
